map_port_arbiter: RTL and testbench
===================================

# map_port_arbiter

Shares the single read/write port B of the map tile memory (4-bit tiles, 32×36 words) between several game-logic requesters: pacman tile lookup, candy/power-cookie clearing, and the four enemy movement engines. Round-robin arbitration, one access per `vga_pix_clk`, registered BRAM-side outputs, and read data returned with a per-requester valid strobe. It sits between the game logic and `dual_port_bram` port B; port A (beam drawing) is untouched.

## Interface

Parameters:
- `N_REQ`, 6: number of requesters; index 0 = pacman read, 1 = candy clear, 2..5 = red/blue/yellow/pink.
- `COLS`, 28: valid tile columns (x 0..27).
- `ROWS`, 36: valid tile rows (y 0..35).
- `STRIDE`, 32: words per map row in memory.
- `OOB_TILE`, 4'hF: data returned for out-of-range reads.

Ports:
- `vga_pix_clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester access request.
- `we`  in  N_REQ  1 = write, 0 = read.
- `tx`  in  N_REQ×5  tile column, requester i at bits [5i+4:5i].
- `ty`  in  N_REQ×6  tile row, requester i at bits [6i+5:6i].
- `wdata`  in  N_REQ×4  write tile value.
- `gnt`  out  N_REQ  one-hot (or zero) acceptance, combinational.
- `rvalid`  out  N_REQ  one-hot read-data strobe.
- `rdata`  out  4  shared read data, qualified by `rvalid`.
- `bram_addrb`  out  11  memory address.
- `bram_web`  out  1  memory write enable.
- `bram_dib`  out  4  memory write data.
- `bram_doutb`  in  4  memory read data (1-cycle latency).

## Operation

- Handshake: request i accepted at the rising edge where `req[i] & gnt[i]`. Requester holds `req`, `we`, `tx`, `ty`, `wdata` stable until accepted; may keep `req` high for back-to-back accesses.
- Arbitration: registered pointer `last` (last accepted index). `gnt` = first asserted `req` searching `last+1, last+2, …` modulo N_REQ. At most one `gnt` bit per cycle; `gnt` = 0 when `req` = 0. `last` updates only on acceptance.
- Address: `addr = ty*STRIDE + tx`, i.e. `{ty, tx}` for STRIDE = 32; 11 bits, no overflow possible.
- Range check: `tx >= COLS` or `ty >= ROWS` is out-of-range. OOB write: accepted, dropped (`bram_web` stays 0). OOB read: accepted, no BRAM access required; `rdata = OOB_TILE` with normal `rvalid` timing.
- Writes never produce `rvalid`.
- Idle cycles: `bram_web` = 0; `bram_addrb`/`bram_dib` hold last value.
- Ordering: accesses reach the BRAM in acceptance order; a read accepted after a write to the same tile returns the written value.

## Timing

- Cycle N: acceptance edge at end of N.
- Cycle N+1: `bram_addrb`, `bram_web`, `bram_dib` driven from registers.
- Cycle N+2: `rvalid[i]` = 1 for one cycle, `rdata` = `bram_doutb` (or OOB_TILE via registered flag).
- Read latency 2 cycles from acceptance; throughput 1 access/cycle; worst-case wait with continuous contention N_REQ−1 cycles.
- Reset (asynchronous assert): `last` = N_REQ−1 (requester 0 wins first), `bram_web` = 0, `bram_addrb` = 0, `bram_dib` = 0, `rvalid` = 0, `rdata` = 0, in-flight pipeline flags cleared. Accesses in flight at reset are lost; no `rvalid` emerges afterwards. `gnt` is not issued while `rst_n` = 0.
- Simultaneous requests: exactly one accepted per cycle; others wait with `gnt` = 0.

## Test plan

- Reset, then single read: `req[0]`, tx=3, ty=2 → `gnt[0]` same cycle; `bram_addrb` = 67, `bram_web` = 0 at N+1; `rvalid[0]` = 1, `rdata` = memory[67] at N+2.
- All six `req` high continuously → grants 0,1,2,3,4,5,0,… one per cycle; each `rvalid[i]` two cycles after its `gnt[i]`.
- Write then read same tile: `req[1]` write tx=5, ty=10, wdata=0 accepted at N; `req[0]` read same tile accepted at N+1 → `rvalid[0]` at N+3 with `rdata` = 0.
- Out-of-range: read tx=28, ty=0 → `rvalid` at N+2 with `rdata` = 4'hF; write ty=36 → `bram_web` never asserted.
- Reset mid-flight: accept read at N, deassert `rst_n` during N+1 → `rvalid` = 0 through N+3; first post-reset grant goes to lowest-index requester.
- Fairness: `req[2]` held high, `req[4]` pulsed → `req[4]` accepted within N_REQ−1 cycles, `req[2]` not starved.

Source files
------------

// File: rtl/map_port_arbiter.sv
// Round-robin arbiter sharing map tile memory port B between game-logic requesters.
// Grants are combinational; BRAM-side signals are registered and reads return two cycles after acceptance.
module map_port_arbiter #(
  parameter int          N_REQ    = 6,
  parameter int          COLS     = 28,
  parameter int          ROWS     = 36,
  parameter int          STRIDE   = 32,
  parameter logic [3:0]  OOB_TILE = 4'hF
) (
  input  logic               vga_pix_clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   we,
  input  logic [N_REQ*5-1:0] tx,
  input  logic [N_REQ*6-1:0] ty,
  input  logic [N_REQ*4-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rvalid,
  output logic [3:0]         rdata,
  output logic [10:0]        bram_addrb,
  output logic               bram_web,
  output logic [3:0]         bram_dib,
  input  logic [3:0]         bram_doutb
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [4:0]       tx_a [N_REQ];
  logic [5:0]       ty_a [N_REQ];
  logic [3:0]       wd_a [N_REQ];

  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    sel_s, idx_s;
  logic             acc_s;
  logic             we_sel_s;
  logic             oob_s;
  logic [10:0]      addr_s;

  logic [10:0]      addr_q, addr_d;
  logic             web_q, web_d;
  logic [3:0]       dib_q, dib_d;
  logic [N_REQ-1:0] rd_id_q, rd_id_d;
  logic             rd_oob_q, rd_oob_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic             rd_oob2_q, rd_oob2_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign tx_a[i] = tx[5*i +: 5];
    assign ty_a[i] = ty[6*i +: 6];
    assign wd_a[i] = wdata[4*i +: 4];
  end

  // Rotating search starting just after the last accepted requester; nothing is granted in reset.
  always_comb begin
    acc_s = 1'b0;
    sel_s = '0;
    idx_s = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = IW'((int'(last_q) + k) % N_REQ);
      if (!acc_s && req[idx_s]) begin
        acc_s = 1'b1;
        sel_s = idx_s;
      end else begin
        acc_s = acc_s;
      end
    end
    if (!rst_n) begin
      acc_s = 1'b0;
    end else begin
      acc_s = acc_s;
    end
  end

  // One-hot grant vector from the selected index.
  always_comb begin
    gnt = '0;
    if (acc_s) begin
      gnt[sel_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Address formation and range check of the granted access.
  always_comb begin
    we_sel_s = we[sel_s];
    addr_s   = 11'((int'(ty_a[sel_s]) * STRIDE) + int'(tx_a[sel_s]));
    oob_s    = (int'(tx_a[sel_s]) >= COLS) || (int'(ty_a[sel_s]) >= ROWS);
  end

  // Next-state: out-of-range accesses never touch the BRAM, idle cycles hold address and data.
  always_comb begin
    last_d    = acc_s ? sel_s : last_q;
    web_d     = acc_s && we_sel_s && !oob_s;
    addr_d    = (acc_s && !oob_s) ? addr_s : addr_q;
    dib_d     = (acc_s && we_sel_s && !oob_s) ? wd_a[sel_s] : dib_q;
    rd_id_d   = (acc_s && !we_sel_s) ? gnt : {N_REQ{1'b0}};
    rd_oob_d  = oob_s;
    rvalid_d  = rd_id_q;
    rd_oob2_d = rd_oob_q;
  end

  // Arbitration pointer and two-stage access pipeline.
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= IW'(N_REQ - 1);
      addr_q    <= 11'd0;
      web_q     <= 1'b0;
      dib_q     <= 4'd0;
      rd_id_q   <= {N_REQ{1'b0}};
      rd_oob_q  <= 1'b0;
      rvalid_q  <= {N_REQ{1'b0}};
      rd_oob2_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      addr_q    <= addr_d;
      web_q     <= web_d;
      dib_q     <= dib_d;
      rd_id_q   <= rd_id_d;
      rd_oob_q  <= rd_oob_d;
      rvalid_q  <= rvalid_d;
      rd_oob2_q <= rd_oob2_d;
    end
  end

  // BRAM read data arrives in the same cycle as the strobe, so only the selection is registered.
  always_comb begin
    if (|rvalid_q) begin
      rdata = rd_oob2_q ? OOB_TILE : bram_doutb;
    end else begin
      rdata = 4'd0;
    end
  end

  assign rvalid     = rvalid_q;
  assign bram_addrb = addr_q;
  assign bram_web   = web_q;
  assign bram_dib   = dib_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Self-checking bench for map_port_arbiter: fixed vectors, directed corner sequences and
// randomized traffic against a behavioural round-robin / memory reference model.
module tb_map_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  req, we;
  logic [29:0] tx;
  logic [35:0] ty;
  logic [23:0] wdata;
  logic [5:0]  gnt, rvalid;
  logic [3:0]  rdata, bram_dib, bram_doutb;
  logic [10:0] bram_addrb;
  logic        bram_web;

  always #5 clk = ~clk;

  map_port_arbiter dut (
    .vga_pix_clk(clk), .rst_n(rst_n), .req(req), .we(we), .tx(tx), .ty(ty), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .bram_addrb(bram_addrb), .bram_web(bram_web),
    .bram_dib(bram_dib), .bram_doutb(bram_doutb)
  );

  // Behavioural BRAM, one-cycle read latency
  logic [3:0] mem [2048];
  always @(posedge clk) begin
    if (bram_web) mem[bram_addrb] <= bram_dib;
    bram_doutb <= mem[bram_addrb];
  end

  function automatic logic [3:0] pat(int a);
    return 4'((a * 7 + 3) & 15);
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state
  typedef struct { int due; int id; logic [3:0] d; } rd_t;
  rd_t         pend[$];
  int          m_last;
  logic [3:0]  shadow [2048];
  logic        exp_web, exp_chk_addr;
  logic [10:0] exp_addr;
  logic [3:0]  exp_dib;
  int          cyc;
  logic [5:0]  obs_gnt, obs_rv;
  logic [3:0]  obs_rd;
  logic        obs_web;
  logic [10:0] obs_addr;

  function automatic logic [5:0] ref_gnt(logic [5:0] r, int last);
    for (int k = 1; k <= 6; k++) begin
      int i = (last + k) % 6;
      if (r[i]) return 6'(1 << i);
    end
    return 6'b0;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_last = 5;
    exp_web = 1'b0;
    exp_chk_addr = 1'b0;
  endtask

  task automatic step();
    logic [5:0] eg, erv;
    logic [3:0] erd;
    int idx, txi, tyi, a;
    bit oob;
    @(negedge clk);
    obs_gnt = gnt; obs_rv = rvalid; obs_rd = rdata; obs_web = bram_web; obs_addr = bram_addrb;
    eg  = rst_n ? ref_gnt(req, m_last) : 6'b0;
    erv = 6'b0;
    erd = 4'd0;
    foreach (pend[j]) if (pend[j].due == cyc) begin erv[pend[j].id] = 1'b1; erd = pend[j].d; end
    check("gnt", gnt, eg);
    check("rvalid", rvalid, erv);
    if (erv != 6'b0 || !rst_n) check("rdata", rdata, erd);
    check("bram_web", bram_web, exp_web);
    if (exp_web) check("bram_dib", bram_dib, exp_dib);
    if (exp_web || exp_chk_addr) check("bram_addrb", bram_addrb, exp_addr);
    if (!rst_n) begin
      check("rst_addrb", bram_addrb, 0);
      check("rst_dib", bram_dib, 0);
    end
    exp_web = 1'b0;
    exp_chk_addr = 1'b0;
    if (eg != 6'b0) begin
      idx = 0;
      for (int k = 0; k < 6; k++) if (eg[k]) idx = k;
      txi = int'(tx[idx*5 +: 5]);
      tyi = int'(ty[idx*6 +: 6]);
      a   = tyi * 32 + txi;
      oob = (txi >= 28) || (tyi >= 36);
      m_last = idx;
      if (we[idx]) begin
        if (!oob) begin
          shadow[a] = wdata[idx*4 +: 4];
          exp_web = 1'b1; exp_addr = 11'(a); exp_dib = wdata[idx*4 +: 4];
        end
      end else begin
        pend.push_back('{due: cyc + 2, id: idx, d: (oob ? 4'hF : shadow[a])});
        if (!oob) begin exp_chk_addr = 1'b1; exp_addr = 11'(a); end
      end
    end
    for (int j = pend.size() - 1; j >= 0; j--) if (pend[j].due <= cyc) pend.delete(j);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input int i, input bit r, input bit w, input int x, input int y, input int d);
    req[i] = r; we[i] = w;
    tx[i*5 +: 5] = 5'(x); ty[i*6 +: 6] = 6'(y); wdata[i*4 +: 4] = 4'(d);
  endtask

  task automatic clear_all();
    req = 6'b0; we = 6'b0; tx = 30'b0; ty = 36'b0; wdata = 24'b0;
  endtask

  typedef struct { logic [5:0] r; logic [5:0] eg; } vec_t;
  vec_t tbl [19];
  int   waited, g2;
  bit   got4;

  initial begin
    tbl[0]  = '{6'b111111, 6'b000010}; tbl[1]  = '{6'b111111, 6'b000100};
    tbl[2]  = '{6'b000001, 6'b000001}; tbl[3]  = '{6'b000000, 6'b000000};
    tbl[4]  = '{6'b100001, 6'b100000}; tbl[5]  = '{6'b100001, 6'b000001};
    tbl[6]  = '{6'b010100, 6'b000100}; tbl[7]  = '{6'b010100, 6'b010000};
    tbl[8]  = '{6'b010100, 6'b000100}; tbl[9]  = '{6'b101000, 6'b001000};
    tbl[10] = '{6'b000010, 6'b000010}; tbl[11] = '{6'b100000, 6'b100000};
    tbl[12] = '{6'b111111, 6'b000001}; tbl[13] = '{6'b111111, 6'b000010};
    tbl[14] = '{6'b111111, 6'b000100}; tbl[15] = '{6'b111111, 6'b001000};
    tbl[16] = '{6'b111111, 6'b010000}; tbl[17] = '{6'b111111, 6'b100000};
    tbl[18] = '{6'b111111, 6'b000001};

    for (int a = 0; a < 2048; a++) begin mem[a] = pat(a); shadow[a] = pat(a); end
    clear_all();
    rst_n = 1'b0;
    model_reset();
    cyc = 0;
    step();
    req = 6'h3F;
    step();
    check("rst_gnt", obs_gnt, 0);
    clear_all();
    rst_n = 1'b1;

    // Single read tx=3, ty=2 -> address 67
    drive(0, 1, 0, 3, 2, 0);
    step(); check("single_gnt", obs_gnt, 6'b000001);
    clear_all();
    step(); check("single_addr", obs_addr, 67); check("single_web", obs_web, 0);
    step(); check("single_rv", obs_rv, 6'b000001); check("single_rdata", obs_rd, 8);

    // Arbitration vectors
    for (int i = 0; i < 6; i++) drive(i, 0, 0, i + 1, 2 * i, 0);
    for (int v = 0; v < 19; v++) begin
      req = tbl[v].r;
      step();
      check("tbl_gnt", obs_gnt, tbl[v].eg);
    end
    clear_all();
    step(); step();

    // Write then read of the same tile
    drive(1, 1, 1, 5, 10, 0);
    step(); check("wr_gnt", obs_gnt, 6'b000010);
    clear_all();
    drive(0, 1, 0, 5, 10, 0);
    step(); check("rd_gnt", obs_gnt, 6'b000001);
    clear_all();
    step();
    step(); check("wr_rd_rv", obs_rv, 6'b000001); check("wr_rd_data", obs_rd, 0);

    // Out-of-range read and write
    drive(2, 1, 0, 28, 0, 0);
    step(); clear_all();
    step();
    step(); check("oob_rv", obs_rv, 6'b000100); check("oob_rdata", obs_rd, 15);
    drive(3, 1, 1, 1, 36, 5);
    step(); check("oobw_gnt", obs_gnt, 6'b001000);
    clear_all();
    step(); check("oobw_web1", obs_web, 0);
    step(); check("oobw_web2", obs_web, 0);

    // Reset while a read is in flight
    drive(0, 1, 0, 7, 7, 0);
    step(); check("mid_gnt", obs_gnt, 6'b000001);
    clear_all();
    #2 rst_n = 1'b0;
    model_reset();
    for (int k = 1; k <= 3; k++) begin
      step(); check("mid_rv", obs_rv, 0);
    end
    rst_n = 1'b1;
    req = 6'h3F;
    step(); check("post_rst_gnt", obs_gnt, 6'b000001);
    clear_all();
    step(); step();

    // Fairness: req[2] held, req[4] pulsed
    drive(2, 1, 0, 4, 4, 0);
    g2 = 0;
    step(); step();
    drive(4, 1, 0, 6, 6, 0);
    got4 = 1'b0; waited = 0;
    for (int k = 0; k < 6 && !got4; k++) begin
      step();
      if (obs_gnt[2]) g2++;
      if (obs_gnt[4]) got4 = 1'b1; else waited++;
    end
    check("fair_got4", got4, 1);
    check("fair_wait_le5", waited <= 5, 1);
    req[4] = 1'b0;
    step(); if (obs_gnt[2]) g2++;
    check("fair_no_starve", g2 > 0, 1);
    clear_all();
    step(); step();

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 6; i++) begin
        if (!(req[i] && !obs_gnt[i])) begin
          if ($urandom_range(0, 99) < 60)
            drive(i, 1, $urandom_range(0, 2) == 0, $urandom_range(0, 31), $urandom_range(0, 39),
                  $urandom_range(0, 15));
          else
            req[i] = 1'b0;
        end
      end
      step();
    end
    clear_all();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
